// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream selector with a registered output stage.
// The channel comes from the sel port (MODE=0) or from round-robin arbitration (MODE=1).
module stream_mux_rr #(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned MODE   = 0,
    localparam int unsigned SELW  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SELW-1:0]         sel,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SELW-1:0]         out_ch,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state;
    logic [SELW-1:0] last;
    logic            load_en;
    logic            pick_vld;
    logic [SELW-1:0] pick;
    logic [SELW-1:0] cand;
    logic [WIDTH-1:0] pick_data;
    logic            sel_bad;

    assign load_en   = (state == EMPTY) || out_ready;
    assign out_valid = (state == FULL);

    // Channel choice. In round-robin mode the loop runs from the farthest candidate
    // to the nearest, so the first valid channel after last is the one that remains.
    always_comb begin
        sel_bad  = 1'b0;
        pick_vld = 1'b0;
        pick     = '0;
        cand     = '0;
        if (MODE == 0) begin
            sel_bad = (32'(sel) >= NUM_CH);
            if (!sel_bad) begin
                pick     = sel;
                pick_vld = in_valid[sel];
            end
        end else begin
            for (int unsigned k = NUM_CH; k >= 1; k--) begin
                cand = SELW'((32'(last) + k) % NUM_CH);
                if (in_valid[cand]) begin
                    pick_vld = 1'b1;
                    pick     = cand;
                end
            end
        end
    end

    always_comb begin
        pick_data = '0;
        in_ready  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (pick == SELW'(i)) begin
                pick_data   = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = !rst && load_en && pick_vld;
            end
        end
    end

    // Output register: load on a grant, drain when consumed with no grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            out_data <= '0;
            out_ch   <= '0;
            sel_err  <= 1'b0;
            last     <= SELW'(NUM_CH - 1);
        end else begin
            sel_err <= load_en && sel_bad;
            if (load_en) begin
                if (pick_vld) begin
                    state    <= FULL;
                    out_data <= pick_data;
                    out_ch   <= pick;
                    if (MODE != 0) begin
                        last <= pick;
                    end
                end else begin
                    state <= EMPTY;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed self-checking bench for stream_mux_rr: select mode, round-robin mode,
// and a 3-channel select instance exercising the out-of-range select error.
module tb_stream_mux_rr;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // u0: MODE=0, NUM_CH=4
    logic [1:0]  sel0 = '0;
    logic [11:0] in_data0 = '0;
    logic [3:0]  in_valid0 = '0;
    logic [3:0]  in_ready0;
    logic [2:0]  out_data0;
    logic [1:0]  out_ch0;
    logic        out_valid0;
    logic        out_ready0 = 1'b1;
    logic        sel_err0;

    // u1: MODE=1, NUM_CH=4
    logic [1:0]  sel1 = '0;
    logic [11:0] in_data1 = '0;
    logic [3:0]  in_valid1 = '0;
    logic [3:0]  in_ready1;
    logic [2:0]  out_data1;
    logic [1:0]  out_ch1;
    logic        out_valid1;
    logic        out_ready1 = 1'b1;
    logic        sel_err1;

    // u2: MODE=0, NUM_CH=3
    logic [1:0]  sel2 = '0;
    logic [8:0]  in_data2 = '0;
    logic [2:0]  in_valid2 = '0;
    logic [2:0]  in_ready2;
    logic [2:0]  out_data2;
    logic [1:0]  out_ch2;
    logic        out_valid2;
    logic        out_ready2 = 1'b1;
    logic        sel_err2;

    stream_mux_rr #(.WIDTH(3), .NUM_CH(4), .MODE(0)) u0 (
        .clk(clk), .rst(rst), .sel(sel0), .in_data(in_data0), .in_valid(in_valid0),
        .in_ready(in_ready0), .out_data(out_data0), .out_ch(out_ch0),
        .out_valid(out_valid0), .out_ready(out_ready0), .sel_err(sel_err0));

    stream_mux_rr #(.WIDTH(3), .NUM_CH(4), .MODE(1)) u1 (
        .clk(clk), .rst(rst), .sel(sel1), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .out_data(out_data1), .out_ch(out_ch1),
        .out_valid(out_valid1), .out_ready(out_ready1), .sel_err(sel_err1));

    stream_mux_rr #(.WIDTH(3), .NUM_CH(3), .MODE(0)) u2 (
        .clk(clk), .rst(rst), .sel(sel2), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .out_data(out_data2), .out_ch(out_ch2),
        .out_valid(out_valid2), .out_ready(out_ready2), .sel_err(sel_err2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; combinational checks at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #4;
    endtask

    logic [1:0] g;

    initial begin
        tick();
        tick();
        in_valid1 = 4'b1111;
        mid();
        chk("rst_in_ready", 32'(in_ready1), 32'h0);
        chk("rst_valid0", 32'(out_valid0), 32'h0);
        chk("rst_data0", 32'(out_data0), 32'h0);
        chk("rst_ch0", 32'(out_ch0), 32'h0);
        chk("rst_err0", 32'(sel_err0), 32'h0);
        chk("rst_valid1", 32'(out_valid1), 32'h0);
        chk("rst_valid2", 32'(out_valid2), 32'h0);
        tick();
        rst = 1'b0;
        in_valid1 = 4'b0000;

        // Select mode basic
        in_data0  = {3'h5, 3'h3, 3'h1, 3'h2};
        in_valid0 = 4'b1111;
        sel0 = 2'd0;
        mid();
        chk("m0_ready_sel0", 32'(in_ready0), 32'h1);
        tick();
        chk("m0_data_sel0", 32'(out_data0), 32'h2);
        chk("m0_ch_sel0", 32'(out_ch0), 32'h0);
        chk("m0_valid_sel0", 32'(out_valid0), 32'h1);
        sel0 = 2'd1;
        mid();
        chk("m0_ready_sel1", 32'(in_ready0), 32'h2);
        tick();
        chk("m0_data_sel1", 32'(out_data0), 32'h1);
        chk("m0_ch_sel1", 32'(out_ch0), 32'h1);

        // Backpressure: hold, then reload without a bubble
        out_ready0 = 1'b0;
        sel0 = 2'd2;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("bp_ready", 32'(in_ready0), 32'h0);
            tick();
            chk("bp_data", 32'(out_data0), 32'h1);
            chk("bp_ch", 32'(out_ch0), 32'h1);
            chk("bp_valid", 32'(out_valid0), 32'h1);
        end
        out_ready0 = 1'b1;
        mid();
        chk("bp_release_ready", 32'(in_ready0), 32'h4);
        tick();
        chk("bp_release_data", 32'(out_data0), 32'h3);
        chk("bp_release_ch", 32'(out_ch0), 32'h2);
        in_valid0 = 4'b0000;
        mid();
        chk("drain_ready", 32'(in_ready0), 32'h0);
        tick();
        chk("drain_valid", 32'(out_valid0), 32'h0);

        // Round-robin fairness: 0,1,2,3,0,1,2,3
        in_data1  = {3'd7, 3'd6, 3'd5, 3'd4};
        in_valid1 = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            g = 2'(i);
            mid();
            chk("rr_ready", 32'(in_ready1), 32'h1 << g);
            tick();
            chk("rr_ch", 32'(out_ch1), 32'(g));
            chk("rr_data", 32'(out_data1), 32'(g) + 32'd4);
            chk("rr_valid", 32'(out_valid1), 32'h1);
        end

        // Sparse after a grant to ch3: 2,3,2 back to back
        in_valid1 = 4'b1100;
        for (int i = 0; i < 3; i++) begin
            g = (i == 1) ? 2'd3 : 2'd2;
            mid();
            chk("sp_ready", 32'(in_ready1), 32'h1 << g);
            tick();
            chk("sp_ch", 32'(out_ch1), 32'(g));
            chk("sp_data", 32'(out_data1), 32'(g) + 32'd4);
            chk("sp_valid", 32'(out_valid1), 32'h1);
        end

        // Reset while a word is held under backpressure
        out_ready1 = 1'b0;
        rst = 1'b1;
        mid();
        chk("rstmid_ready", 32'(in_ready1), 32'h0);
        tick();
        chk("rstmid_valid", 32'(out_valid1), 32'h0);
        chk("rstmid_data", 32'(out_data1), 32'h0);
        chk("rstmid_ch", 32'(out_ch1), 32'h0);
        rst = 1'b0;
        in_valid1  = 4'b0110;
        out_ready1 = 1'b1;
        mid();
        chk("post_rst_ready", 32'(in_ready1), 32'h2);
        tick();
        chk("post_rst_ch", 32'(out_ch1), 32'h1);
        chk("post_rst_data", 32'(out_data1), 32'h5);

        // Out-of-range select on the 3-channel instance
        in_data2  = {3'd3, 3'd6, 3'd1};
        in_valid2 = 3'b111;
        sel2 = 2'd3;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("selerr_ready", 32'(in_ready2), 32'h0);
            tick();
            chk("selerr_pulse", 32'(sel_err2), 32'h1);
            chk("selerr_valid", 32'(out_valid2), 32'h0);
        end
        sel2 = 2'd1;
        mid();
        chk("sel_ok_ready", 32'(in_ready2), 32'h2);
        tick();
        chk("sel_ok_err", 32'(sel_err2), 32'h0);
        chk("sel_ok_data", 32'(out_data2), 32'h6);
        chk("sel_ok_ch", 32'(out_ch2), 32'h1);
        chk("sel_ok_valid", 32'(out_valid2), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
